// File: rtl/nmr_seq_pkg.sv
// +----------------------------------------------------------------------+
// | nmr_seq_pkg : shared state encoding and defaults for the NMR scan    |
// | sequencer.                          Revision: 1.0                    |
// +----------------------------------------------------------------------+
`default_nettype none

package nmr_seq_pkg;

   localparam int STATE_W             = 6;
   localparam int ACK_TIMEOUT_DEFAULT = 16;

   typedef logic [STATE_W-1:0] state_t;

   localparam logic [STATE_W-1:0] ST_IDLE     = 6'b000001;
   localparam logic [STATE_W-1:0] ST_LAUNCH   = 6'b000010;
   localparam logic [STATE_W-1:0] ST_WAIT_ACK = 6'b000100;
   localparam logic [STATE_W-1:0] ST_RUN      = 6'b001000;
   localparam logic [STATE_W-1:0] ST_REPDLY   = 6'b010000;
   localparam logic [STATE_W-1:0] ST_FINISH   = 6'b100000;

endpackage

`default_nettype wire

// File: rtl/nmr_delay_counter.sv
// +----------------------------------------------------------------------+
// | nmr_delay_counter : loadable down-counter, terminal count on the     |
// | last cycle of the loaded delay.     Revision: 1.0                    |
// +----------------------------------------------------------------------+
`default_nettype none

module nmr_delay_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             en_i,
   output logic             tc_o
);

   logic [WIDTH-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   // A load of N gives N enabled cycles; tc marks the last of them.
   assign tc_o = (cnt_q == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/nmr_scan_sequencer.sv
// +----------------------------------------------------------------------+
// | nmr_scan_sequencer : launches NUM_SCAN pulse-program scans separated |
// | by REP_DELAY cycles. Option macro: NMR_SCAN_SEQ_PHASE_CYC_EN.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module nmr_scan_sequencer
   import nmr_seq_pkg::*;
#(
   parameter int SCAN_CNT_WIDTH  = 16,
   parameter int REP_DELAY_WIDTH = 32,
   parameter int ACK_TIMEOUT     = ACK_TIMEOUT_DEFAULT
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic                       START,
   input  logic                       ABORT,
   input  logic [SCAN_CNT_WIDTH-1:0]  NUM_SCAN,
   input  logic [REP_DELAY_WIDTH-1:0] REP_DELAY,
   input  logic                       PP_FSMSTAT,
   output logic                       PP_START,
   output logic                       PP_PHASE_CYC,
   output logic                       BUSY,
   output logic                       SCAN_DONE,
   output logic [SCAN_CNT_WIDTH-1:0]  SCAN_IDX,
   output logic                       DONE,
   output logic                       ERR
);

   localparam int                ACK_W    = $clog2(ACK_TIMEOUT + 1);
   localparam logic [ACK_W-1:0]  ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

   state_t                       state_q, state_d;
   logic [SCAN_CNT_WIDTH-1:0]    num_q, idx_q;
   logic [REP_DELAY_WIDTH-1:0]   rep_q;
   logic [ACK_W-1:0]             ack_cnt_q;
   logic                         abort_q, busy_q, done_q, scan_done_q, err_q;
   logic                         w_accept, w_abort, w_last, w_dly_tc, w_dly_load;
   logic [SCAN_CNT_WIDTH-1:0]    w_idx_inc;

   assign w_accept  = (state_q == ST_IDLE) && START;
   assign w_abort   = abort_q | ABORT;
   assign w_idx_inc = idx_q + 1'b1;
   assign w_last    = (w_idx_inc == num_q);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (START) state_d = (NUM_SCAN == '0) ? ST_FINISH : ST_LAUNCH;
         ST_LAUNCH:   state_d = ST_WAIT_ACK;
         ST_WAIT_ACK: begin
            if (PP_FSMSTAT)                state_d = ST_RUN;
            else if (ack_cnt_q == ACK_LAST) state_d = ST_FINISH;
         end
         ST_RUN: begin
            if (!PP_FSMSTAT) begin
               if (w_last || w_abort)   state_d = ST_FINISH;
               else if (rep_q == '0)    state_d = ST_LAUNCH;
               else                     state_d = ST_REPDLY;
            end
         end
         ST_REPDLY: begin
            if (w_abort)       state_d = ST_FINISH;
            else if (w_dly_tc) state_d = ST_LAUNCH;
         end
         ST_FINISH:   state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= ST_IDLE;
         num_q       <= '0;
         rep_q       <= '0;
         idx_q       <= '0;
         ack_cnt_q   <= '0;
         abort_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         scan_done_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         done_q      <= (state_q == ST_FINISH);
         scan_done_q <= 1'b0;
         abort_q     <= (state_q == ST_IDLE) ? 1'b0 : (abort_q | ABORT);
         ack_cnt_q   <= (state_q == ST_WAIT_ACK) ? ack_cnt_q + 1'b1 : '0;
         if (w_accept) begin
            num_q  <= NUM_SCAN;
            rep_q  <= REP_DELAY;
            idx_q  <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b1;
         end
         if (state_q == ST_FINISH) busy_q <= 1'b0;
         if ((state_q == ST_WAIT_ACK) && (state_d == ST_FINISH)) err_q <= 1'b1;
         if ((state_q == ST_RUN) && !PP_FSMSTAT) begin
            scan_done_q <= 1'b1;
            idx_q       <= w_idx_inc;
         end
      end
   end

   assign w_dly_load = (state_q == ST_RUN) && (state_d == ST_REPDLY);

   nmr_delay_counter #(
      .WIDTH      (REP_DELAY_WIDTH)
   ) u_rep_dly (
      .clk_i      (CLK),
      .rst_i      (RESET),
      .load_i     (w_dly_load),
      .load_val_i (rep_q),
      .en_i       (state_q == ST_REPDLY),
      .tc_o       (w_dly_tc)
   );

`ifdef NMR_SCAN_SEQ_PHASE_CYC_EN
   logic phase_q;

   // Toggles only on re-entry to LAUNCH, so scan 0 always starts at phase 0.
   always_ff @(posedge CLK) begin
      if (RESET || w_accept) begin
         phase_q <= 1'b0;
      end else if ((state_d == ST_LAUNCH) && (state_q != ST_IDLE)) begin
         phase_q <= ~phase_q;
      end
   end

   assign PP_PHASE_CYC = phase_q;
`else
   assign PP_PHASE_CYC = 1'b0;
`endif

   assign PP_START  = (state_q == ST_LAUNCH);
   assign BUSY      = busy_q;
   assign SCAN_DONE = scan_done_q;
   assign SCAN_IDX  = idx_q;
   assign DONE      = done_q;
   assign ERR       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_nmr_scan_sequencer.sv
// +----------------------------------------------------------------------+
// | tb_nmr_scan_sequencer : directed table-driven bench with a simple    |
// | pulse-program model.                Revision: 1.0                    |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_nmr_scan_sequencer;

   localparam int ACK_T = 16;
`ifdef NMR_SCAN_SEQ_PHASE_CYC_EN
   localparam bit PHASE_EN = 1'b1;
`else
   localparam bit PHASE_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] num_scan = '0;
   logic [31:0] rep_delay = '0;
   logic        fsmstat = 1'b0;
   logic        pp_start, pp_phase, busy, scan_done, done, err;
   logic [15:0] scan_idx;

   nmr_scan_sequencer dut (
      .CLK          (clk),
      .RESET        (rst),
      .START        (start),
      .ABORT        (abort),
      .NUM_SCAN     (num_scan),
      .REP_DELAY    (rep_delay),
      .PP_FSMSTAT   (fsmstat),
      .PP_START     (pp_start),
      .PP_PHASE_CYC (pp_phase),
      .BUSY         (busy),
      .SCAN_DONE    (scan_done),
      .SCAN_IDX     (scan_idx),
      .DONE         (done),
      .ERR          (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Pulse-program model and event monitor
   int pp_busy_len = 4;
   bit pp_en = 1'b1;
   int pp_rem = 0;
   int fall_cyc = 0;
   bit fall_valid = 1'b0;
   int ps_n = 0, sd_n = 0, done_n = 0, gap_n = 0;
   int ps_cyc = 0, done_cyc = 0;
   int gap_log [64];
   bit phase_log [64];

   always @(negedge clk) begin
      if (rst) begin
         fsmstat    = 1'b0;
         pp_rem     = 0;
         fall_valid = 1'b0;
      end else begin
         if (pp_rem > 0) begin
            pp_rem = pp_rem - 1;
            if (pp_rem == 0) begin
               fsmstat    = 1'b0;
               fall_cyc   = cyc;
               fall_valid = 1'b1;
            end
         end
         if (pp_start) begin
            if (fall_valid) begin
               gap_log[gap_n % 64] = cyc - fall_cyc - 1;
               gap_n      = gap_n + 1;
               fall_valid = 1'b0;
            end
            phase_log[ps_n % 64] = pp_phase;
            ps_n   = ps_n + 1;
            ps_cyc = cyc;
            if (pp_en) begin
               fsmstat = 1'b1;
               pp_rem  = pp_busy_len;
            end
         end
         if (scan_done) sd_n = sd_n + 1;
         if (done) begin
            done_n     = done_n + 1;
            done_cyc   = cyc;
            fall_valid = 1'b0;
         end
      end
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_done(input string name, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 5000 && !seen; i++) begin
         if (done) seen = 1'b1;
         else @(negedge clk);
      end
      chk({name, "_done_seen"}, seen, 1);
   endtask

   typedef struct {
      logic [15:0] num;
      logic [31:0] rep;
      int          busy_len;
      bit          en;
      int          exp_sd;
      int          exp_idx;
      int          exp_ps;
      int          exp_gaps;
      bit          exp_err;
   } vec_t;

   vec_t vecs [6];

   task automatic run_vec(input int n, input vec_t v);
      int  sd0, ps0, dn0, gp0;
      bit  seen;
      string tag;
      tag = $sformatf("v%0d", n);
      sd0 = sd_n; ps0 = ps_n; dn0 = done_n; gp0 = gap_n;
      num_scan    = v.num;
      rep_delay   = v.rep;
      pp_busy_len = v.busy_len;
      pp_en       = v.en;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_busy_set"}, busy, 1);
      chk({tag, "_err_clr"}, err, 0);
      wait_done(tag, seen);
      chk({tag, "_idx"}, scan_idx, v.exp_idx);
      chk({tag, "_err"}, err, v.exp_err);
      chk({tag, "_busy_clr"}, busy, 0);
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_scan_done_n"}, sd_n - sd0, v.exp_sd);
      chk({tag, "_pp_start_n"}, ps_n - ps0, v.exp_ps);
      chk({tag, "_done_n"}, done_n - dn0, 1);
      chk({tag, "_gap_n"}, gap_n - gp0, v.exp_gaps);
      for (int g = gp0; g < gap_n; g++)
         chk({tag, "_gap"}, gap_log[g % 64], v.rep);
      for (int k = 0; k < ps_n - ps0; k++)
         chk({tag, "_phase"}, phase_log[(ps0 + k) % 64], PHASE_EN ? (k % 2) : 0);
      if (v.exp_err)
         chk({tag, "_timeout_lat"}, done_cyc - ps_cyc, ACK_T + 2);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_ps(input int target, input string name);
      int i;
      for (i = 0; i < 2000 && ps_n < target; i++) @(negedge clk);
      chk({name, "_ps_reached"}, ps_n >= target, 1);
   endtask

   initial begin
      int  sd0, ps0, dn0;
      bit  seen, found;

      //          num   rep busy en  sd idx ps gaps err
      vecs[0] = '{16'd3, 32'd10, 50, 1'b1, 3, 3, 3, 2, 1'b0};
      vecs[1] = '{16'd0, 32'd5,   5, 1'b1, 0, 0, 0, 0, 1'b0};
      vecs[2] = '{16'd4, 32'd0,   3, 1'b1, 4, 4, 4, 3, 1'b0};
      vecs[3] = '{16'd1, 32'd7,   2, 1'b1, 1, 1, 1, 0, 1'b0};
      vecs[4] = '{16'd2, 32'd1,   4, 1'b0, 0, 0, 1, 0, 1'b1};
      vecs[5] = '{16'd2, 32'd1,   4, 1'b1, 2, 2, 2, 1, 1'b0};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_pp_start", pp_start, 0);
      chk("rst_phase", pp_phase, 0);
      chk("rst_busy", busy, 0);
      chk("rst_scan_done", scan_done, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_idx", scan_idx, 0);

      // NUM_SCAN=0: DONE exactly two cycles after the START cycle
      num_scan = 16'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("zero_done_c1", done, 0);
      @(negedge clk);
      chk("zero_done_c2", done, 1);
      chk("zero_pp_start", pp_start, 0);
      repeat (3) @(negedge clk);

      for (int n = 0; n < 6; n++) run_vec(n, vecs[n]);

      // ABORT during REPDLY after scan 2
      sd0 = sd_n; ps0 = ps_n; dn0 = done_n;
      num_scan = 16'd5; rep_delay = 32'd20; pp_busy_len = 5; pp_en = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         if (scan_done && scan_idx == 16'd2) found = 1'b1;
         else @(negedge clk);
      end
      chk("abdly_scan2", found, 1);
      repeat (2) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abdly_not_yet", done, 0);
      @(negedge clk);
      chk("abdly_done", done, 1);
      chk("abdly_idx", scan_idx, 2);
      @(negedge clk);
      chk("abdly_pp_start_n", ps_n - ps0, 2);
      chk("abdly_done_n", done_n - dn0, 1);
      repeat (3) @(negedge clk);

      // ABORT during RUN of scan 2: that scan still completes
      sd0 = sd_n; ps0 = ps_n;
      num_scan = 16'd5; rep_delay = 32'd4; pp_busy_len = 10;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_ps(ps0 + 2, "abrun");
      repeat (4) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_done("abrun", seen);
      chk("abrun_idx", scan_idx, 2);
      @(negedge clk);
      chk("abrun_scan_done_n", sd_n - sd0, 2);
      chk("abrun_pp_start_n", ps_n - ps0, 2);
      repeat (3) @(negedge clk);

      // START while BUSY is ignored
      num_scan = 16'd2; rep_delay = 32'd3; pp_busy_len = 6;
      ps0 = ps_n;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_ps(ps0 + 1, "ign");
      repeat (3) @(negedge clk);
      num_scan = 16'd1; rep_delay = 32'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ign_busy", busy, 1);
      wait_done("ign", seen);
      chk("ign_idx", scan_idx, 2);
      repeat (3) @(negedge clk);

      // RESET during RUN of scan 2
      ps0 = ps_n; dn0 = done_n;
      num_scan = 16'd3; rep_delay = 32'd2; pp_busy_len = 10;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_ps(ps0 + 2, "rrun");
      repeat (4) @(negedge clk);
      chk("rrun_idx_before", scan_idx, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rrun_pp_start", pp_start, 0);
      chk("rrun_busy", busy, 0);
      chk("rrun_scan_done", scan_done, 0);
      chk("rrun_done", done, 0);
      chk("rrun_err", err, 0);
      chk("rrun_idx", scan_idx, 0);
      chk("rrun_phase", pp_phase, 0);
      rst = 1'b0;
      repeat (80) @(negedge clk);
      chk("rrun_no_done", done_n - dn0, 0);
      chk("rrun_no_launch", ps_n - ps0, 2);

      // Recovers cleanly after the mid-run reset
      run_vec(6, '{16'd1, 32'd0, 2, 1'b1, 1, 1, 1, 0, 1'b0});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
